// File: rtl/comp_pkg.sv
// Shared types for the shared-comparator controller and other comparator clients.
package comp_pkg;

  localparam int CMP_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic gt;
    logic lt;
    logic eq;
  } cmp_res_t;

  // Index width for a requester count; never below one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/comp_16b.sv
// 16-bit unsigned magnitude comparator, purely combinational.
module comp_16b (
  output logic        gt,
  output logic        lt,
  output logic        eq,
  input  logic [15:0] a,
  input  logic [15:0] b
);

  // Exactly one of the three flags is high for any operand pair.
  always_comb begin
    gt = (a > b);
    lt = (a < b);
    eq = (a == b);
  end

endmodule

// File: rtl/comp_share_ctrl_rr_pick.sv
// Round-robin selector: first requester at or after last+1, wrapping.
module rr_pick
  import comp_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]        req,
  input  logic [idx_w(N_REQ)-1:0] last,
  output logic [idx_w(N_REQ)-1:0] grant_idx,
  output logic                    any_req
);

  localparam int IW = idx_w(N_REQ);

  logic [IW-1:0] cand;

  // Walk the ring starting one past the last winner; the first hit wins.
  always_comb begin
    grant_idx = '0;
    any_req   = 1'b0;
    cand      = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = IW'((int'(last) + i) % N_REQ);
      if (!any_req && req[cand]) begin
        any_req   = 1'b1;
        grant_idx = cand;
      end
    end
  end

endmodule

// File: rtl/comp_share_ctrl.sv
// Shares one comp_16b among N_REQ requesters: arbitrate, capture, compare, ack.
//
// state | meaning
// IDLE  | waiting for a request; arbitrates and captures operands on a hit
// CMP   | captured operands drive the comparator; result is registered
// RESP  | one-cycle ack to the granted requester; round-robin pointer moves
module comp_share_ctrl
  import comp_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] a_in,
  input  logic [N_REQ*W-1:0] b_in,
  output logic [N_REQ-1:0]   ack,
  output logic               gt_out,
  output logic               lt_out,
  output logic               eq_out,
  output logic               busy
);

  localparam int IW = idx_w(N_REQ);

  if (W != CMP_W) begin : g_w_chk
    $error("comp_share_ctrl: W must equal %0d", CMP_W);
  end
  if (N_REQ < 2 || N_REQ > 8) begin : g_n_chk
    $error("comp_share_ctrl: N_REQ must be in 2..8");
  end

  state_t        state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] last_q, last_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  cmp_res_t      res_q, res_d;

  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic [W-1:0]  a_sel;
  logic [W-1:0]  b_sel;
  logic          cmp_gt;
  logic          cmp_lt;
  logic          cmp_eq;

  rr_pick #(
    .N_REQ(N_REQ)
  ) u_pick (
    .req      (req),
    .last     (last_q),
    .grant_idx(pick_idx),
    .any_req  (pick_any)
  );

  comp_16b u_cmp (
    .gt(cmp_gt),
    .lt(cmp_lt),
    .eq(cmp_eq),
    .a (a_q),
    .b (b_q)
  );

  // Operand mux for the current arbitration winner.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_idx == IW'(i)) begin
        a_sel = a_in[i*W +: W];
        b_sel = b_in[i*W +: W];
      end
    end
  end

  // Next-state logic; operands are captured only at grant so later input changes are ignored.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          a_d     = a_sel;
          b_d     = b_sel;
          state_d = CMP;
        end
      end
      CMP: begin
        res_d.gt = cmp_gt;
        res_d.lt = cmp_lt;
        res_d.eq = cmp_eq;
        state_d  = RESP;
      end
      RESP: begin
        last_d  = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Ack decode and status; ack exists only while in RESP, so reset kills it immediately.
  always_comb begin
    ack = '0;
    for (int i = 0; i < N_REQ; i++) begin
      ack[i] = (state_q == RESP) && (grant_q == IW'(i));
    end
    busy   = (state_q != IDLE);
    gt_out = res_q.gt;
    lt_out = res_q.lt;
    eq_out = res_q.eq;
  end

  // State and datapath registers; last resets to N_REQ-1 so requester 0 goes first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IW'(N_REQ - 1);
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_comp_share_ctrl.sv
// Bench for comp_share_ctrl: directed scenarios plus random traffic against a transaction model.
module tb_comp_share_ctrl;

  localparam int N  = 4;
  localparam int AW = N * 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req = '0;
  logic [AW-1:0] a_in = '0;
  logic [AW-1:0] b_in = '0;
  logic [N-1:0]  ack;
  logic          gt_out;
  logic          lt_out;
  logic          eq_out;
  logic          busy;

  comp_share_ctrl #(.N_REQ(N), .W(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .a_in  (a_in),
    .b_in  (b_in),
    .ack   (ack),
    .gt_out(gt_out),
    .lt_out(lt_out),
    .eq_out(eq_out),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Transaction model: cycles of busy left, served index, result pending/visible, pointer.
  int         m_left  = 0;
  int         m_idx   = 0;
  int         m_last  = N - 1;
  logic [2:0] m_pend  = 3'b000;
  logic [2:0] m_shown = 3'b000;

  int ack_idx_q[$];
  int ack_cyc_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [2:0] ref_cmp(input logic [15:0] a, input logic [15:0] b);
    if (a > b) return 3'b100;
    if (a < b) return 3'b010;
    return 3'b001;
  endfunction

  function automatic logic [15:0] get_a(input int i);
    return 16'(a_in >> (16 * i));
  endfunction

  function automatic logic [15:0] get_b(input int i);
    return 16'(b_in >> (16 * i));
  endfunction

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
    a_in = (a_in & ~(AW'(16'hFFFF) << (16 * i))) | (AW'(a) << (16 * i));
    b_in = (b_in & ~(AW'(16'hFFFF) << (16 * i))) | (AW'(b) << (16 * i));
  endtask

  function automatic int log_idx(input int k);
    return (k < ack_idx_q.size()) ? ack_idx_q[k] : -1;
  endfunction

  function automatic int log_cyc(input int k);
    return (k < ack_cyc_q.size()) ? ack_cyc_q[k] : -1;
  endfunction

  // Advance the model across one rising edge using the inputs presented now.
  task automatic model_step();
    if (rst) begin
      m_left  = 0;
      m_shown = 3'b000;
      m_last  = N - 1;
    end else if (m_left == 2) begin
      m_left  = 1;
      m_shown = m_pend;
    end else if (m_left == 1) begin
      m_left = 0;
      m_last = m_idx;
    end else if (req != 0) begin
      for (int k = 1; k <= N; k++) begin
        if (req[(m_last + k) % N]) begin
          m_idx = (m_last + k) % N;
          break;
        end
      end
      m_pend = ref_cmp(get_a(m_idx), get_b(m_idx));
      m_left = 2;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    chk("busy", 32'(busy), 32'(m_left != 0));
    chk("ack", 32'(ack), (m_left == 1) ? (32'd1 << m_idx) : 32'd0);
    chk("result", 32'({gt_out, lt_out, eq_out}), 32'(m_shown));
    if (ack != 0) begin
      ack_idx_q.push_back($clog2(ack));
      ack_cyc_q.push_back(cyc);
    end
  endtask

  // Run until all requests are served; each requester drops req after its ack unless in keep (once).
  task automatic drain(input int max_cyc, input logic [N-1:0] keep_in);
    logic [N-1:0] keep;
    int n;
    keep = keep_in;
    n = 0;
    while ((req != 0 || m_left != 0) && n < max_cyc) begin
      tick();
      req  = req & ~(ack & ~keep);
      keep = keep & ~ack;
      n++;
    end
    chk("drain_timeout", 32'(req != 0 || m_left != 0), 32'd0);
  endtask

  task automatic rand_op(input int i);
    logic [15:0] a;
    logic [15:0] b;
    a = 16'($urandom);
    case ($urandom_range(0, 3))
      0:       b = a;
      1:       b = a ^ 16'(1 << $urandom_range(0, 15));
      default: b = 16'($urandom);
    endcase
    set_op(i, a, b);
  endtask

  logic [15:0] bnd_a [3] = '{16'h0000, 16'hFFFF, 16'h8000};
  logic [15:0] bnd_b [3] = '{16'hFFFF, 16'hFFFF, 16'h7FFF};
  logic [2:0]  bnd_r [3] = '{3'b010, 3'b001, 3'b100};
  int start;

  initial begin
    // Reset, then idle.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    repeat (10) tick();
    chk("idle_outputs", 32'({ack, busy, gt_out, lt_out, eq_out}), 32'd0);

    // Single request, greater.
    ack_idx_q.delete();
    ack_cyc_q.delete();
    set_op(0, 16'h1234, 16'h1233);
    start = cyc;
    req = 4'b0001;
    drain(20, '0);
    chk("single_idx", 32'(log_idx(0)), 32'd0);
    chk("single_latency", 32'(log_cyc(0) - start), 32'd2);
    chk("single_res", 32'({gt_out, lt_out, eq_out}), 32'(3'b100));

    // Boundary operands on requester 2.
    for (int t = 0; t < 3; t++) begin
      set_op(2, bnd_a[t], bnd_b[t]);
      req = 4'b0100;
      drain(20, '0);
      chk($sformatf("boundary_%0d", t), 32'({gt_out, lt_out, eq_out}), 32'(bnd_r[t]));
    end

    // Contention: all four at once; last is 2 here, so requester 3 leads the ring.
    // Force requester 0 first by a reset so the 0,1,2,3 order applies.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++) set_op(i, 16'(i * 16'h1111), 16'h2222);
    ack_idx_q.delete();
    ack_cyc_q.delete();
    start = cyc;
    req = 4'b1111;
    drain(40, '0);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("cont_idx_%0d", k), 32'(log_idx(k)), 32'(k));
      chk($sformatf("cont_cyc_%0d", k), 32'(log_cyc(k) - start), 32'(2 + 3 * k));
    end

    // Fairness: requester 1 re-requests right after its ack; requester 3 must go first.
    set_op(1, 16'h0010, 16'h0020);
    set_op(3, 16'h0030, 16'h0030);
    ack_idx_q.delete();
    ack_cyc_q.delete();
    req = 4'b1010;
    drain(40, 4'b0010);
    chk("fair_0", 32'(log_idx(0)), 32'd1);
    chk("fair_1", 32'(log_idx(1)), 32'd3);
    chk("fair_2", 32'(log_idx(2)), 32'd1);
    chk("fair_n", 32'(ack_idx_q.size()), 32'd3);

    // Operand stability: A changes during CMP.
    set_op(0, 16'h0005, 16'h0006);
    req = 4'b0001;
    tick();
    set_op(0, 16'hFFFF, 16'h0006);
    drain(20, '0);
    chk("stable_res", 32'({gt_out, lt_out, eq_out}), 32'(3'b010));

    // Reset in CMP: no ack, outputs cleared, priority back to requester 0.
    set_op(0, 16'h0009, 16'h0001);
    set_op(3, 16'h0001, 16'h0009);
    req = 4'b0001;
    tick();
    rst = 1'b1;
    tick();
    chk("rst_mid_outputs", 32'({ack, busy, gt_out, lt_out, eq_out}), 32'd0);
    rst = 1'b0;
    ack_idx_q.delete();
    ack_cyc_q.delete();
    req = 4'b1001;
    drain(20, '0);
    chk("rst_next_0", 32'(log_idx(0)), 32'd0);
    chk("rst_next_1", 32'(log_idx(1)), 32'd3);

    // Random traffic, with occasional resets and operand churn.
    for (int c = 0; c < 800; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < N; i++) begin
        if (!req[i]) begin
          rand_op(i);
          if ($urandom_range(0, 3) == 0) req[i] = 1'b1;
        end else if ($urandom_range(0, 7) == 0) begin
          rand_op(i);
        end
      end
      tick();
      for (int i = 0; i < N; i++) begin
        if (ack[i] && $urandom_range(0, 7) != 0) req[i] = 1'b0;
      end
    end
    rst = 1'b0;
    req = '0;
    drain(20, '0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
